// File: rtl/dbgu_pkg.sv
// dbgu_pkg: shared opcodes, acknowledge bytes, FSM states and sizing helpers
// for the UART debug bus master.
package dbgu_pkg;

  localparam logic [7:0] OP_SET_ADDR = 8'h01;
  localparam logic [7:0] OP_WRITE    = 8'h04;
  localparam logic [7:0] OP_READ     = 8'h05;
  localparam logic [7:0] OP_BURST_WR = 8'h06;
  localparam logic [7:0] OP_BURST_RD = 8'h07;
  localparam logic [7:0] OP_CPU_CLK  = 8'h22;

  localparam logic [7:0] ACK_OK  = 8'hA5;
  localparam logic [7:0] ACK_BAD = 8'hEE;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARGS,
    S_MEM_WR,
    S_MEM_RD,
    S_TX,
    S_ACK
  } state_t;

  function automatic int dbgu_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Index width that never collapses to zero bits for one-byte registers.
  function automatic int dbgu_clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic dbgu_known_op(input logic [7:0] op);
    return (op == OP_SET_ADDR) || (op == OP_WRITE) || (op == OP_READ) ||
           (op == OP_BURST_WR) || (op == OP_BURST_RD) || (op == OP_CPU_CLK);
  endfunction

endpackage

// File: rtl/dbgu_shift.sv
// dbgu_shift: byte-serial little-endian register. Bytes can be written at an
// index (assembling a word from the command stream) or a word can be loaded
// and shifted out least-significant byte first.
module dbgu_shift
  import dbgu_pkg::*;
#(
  parameter int NBYTES = 4,
  parameter int IW     = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_load,
  input  logic [8*NBYTES-1:0]   i_loadVal,
  input  logic                  i_wr,
  input  logic [IW-1:0]         i_idx,
  input  logic [7:0]            i_byte,
  input  logic                  i_shift,
  output logic [8*NBYTES-1:0]   o_q
);

  logic [8*NBYTES-1:0] r_q;

  // Parallel load wins over byte write, which wins over the output shift.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q <= '0;
    end else if (i_load) begin
      r_q <= i_loadVal;
    end else if (i_wr) begin
      r_q[{i_idx, 3'b000} +: 8] <= i_byte;
    end else if (i_shift) begin
      r_q <= r_q >> 8;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/dbgu_burst.sv
// dbgu_burst: UART byte-stream debug master driving a simple valid/ready
// memory bus, with single and burst accesses plus a CPU clock enable.
// Optional feature macro: DBGU_ACK_EN (emit 0xA5 per completed command and
// 0xEE per unknown opcode on the response stream).
module dbgu_burst
  import dbgu_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_BYTES = 4,
  parameter int MAX_BURST  = 256
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic [7:0]              rx_data,
  input  logic                    rx_valid,
  output logic                    rx_ready,
  output logic [7:0]              tx_data,
  output logic                    tx_valid,
  input  logic                    tx_ready,
  output logic                    mem_valid,
  input  logic                    mem_ready,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic [8*DATA_BYTES-1:0] mem_wdata,
  output logic [DATA_BYTES-1:0]   mem_wstrb,
  input  logic [8*DATA_BYTES-1:0] mem_rdata,
  output logic                    cpu_clk_en
);

  localparam int DW  = 8 * DATA_BYTES;
  localparam int AB  = ADDR_W / 8;
  localparam int NB  = dbgu_max(DATA_BYTES, AB);
  localparam int SHW = 8 * NB;
  localparam int IW  = dbgu_clog2_min1(NB);
  localparam int TW  = dbgu_clog2_min1(DATA_BYTES);

  localparam logic [ADDR_W-1:0] LOW_MASK  = ADDR_W'(DATA_BYTES - 1);
  localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(DATA_BYTES);
  localparam logic [IW:0]       LEN_ADDR  = (IW+1)'(AB);
  localparam logic [IW:0]       LEN_DATA  = (IW+1)'(DATA_BYTES);
  localparam logic [IW:0]       LEN_ONE   = (IW+1)'(1);
  localparam logic [TW-1:0]     TX_LAST   = TW'(DATA_BYTES - 1);
  localparam logic [8:0]        BURST_MAX = 9'(MAX_BURST);

`ifdef DBGU_ACK_EN
  localparam state_t FINISH_STATE = S_ACK;
`else
  localparam state_t FINISH_STATE = S_IDLE;
`endif

  state_t            r_state;
  state_t            w_stateNext;
  logic [7:0]        r_op;
  logic [IW-1:0]     r_argCnt;
  logic [IW:0]       r_argLen;
  logic              r_cntPhase;
  logic [8:0]        r_burstLeft;
  logic [ADDR_W-1:0] r_addr;
  logic [TW-1:0]     r_txCnt;
  logic              r_cpuClkEn;
`ifdef DBGU_ACK_EN
  logic [7:0]        r_ackByte;
`endif

  logic              w_rxFire;
  logic              w_lastArg;
  logic              w_lastTx;
  logic              w_moreWords;
  logic              w_rxWr;
  logic              w_txLoad;
  logic              w_txShift;
  logic [SHW-1:0]    w_rxQ;
  logic [SHW-1:0]    w_txQ;
  logic [SHW-1:0]    w_argWord;
  logic [8:0]        w_countClamp;
  logic              w_unusedBits;

  assign w_rxFire    = rx_valid & rx_ready;
  assign w_lastArg   = ({1'b0, r_argCnt} == (r_argLen - LEN_ONE));
  assign w_lastTx    = (r_txCnt == TX_LAST);
  assign w_moreWords = (r_burstLeft > 9'd1);
  assign w_rxWr      = w_rxFire && (r_state == S_ARGS);
  assign w_txLoad    = (r_state == S_MEM_RD) && mem_ready;
  assign w_txShift   = (r_state == S_TX) && tx_ready;

  dbgu_shift #(.NBYTES(NB), .IW(IW)) u_rxShift (
    .clk       (CLK),
    .rst       (RESET),
    .i_load    (1'b0),
    .i_loadVal ('0),
    .i_wr      (w_rxWr),
    .i_idx     (r_argCnt),
    .i_byte    (rx_data),
    .i_shift   (1'b0),
    .o_q       (w_rxQ)
  );

  dbgu_shift #(.NBYTES(NB), .IW(IW)) u_txShift (
    .clk       (CLK),
    .rst       (RESET),
    .i_load    (w_txLoad),
    .i_loadVal (SHW'(mem_rdata)),
    .i_wr      (1'b0),
    .i_idx     ('0),
    .i_byte    (8'h00),
    .i_shift   (w_txShift),
    .o_q       (w_txQ)
  );

  // Argument word as it will look once the byte now on rx_data lands, so
  // the final byte can be acted on in the same cycle it is accepted.
  always_comb begin
    w_argWord = w_rxQ;
    w_argWord[{r_argCnt, 3'b000} +: 8] = rx_data;
  end

  // Burst count byte: zero means the maximum, anything larger is clamped.
  always_comb begin
    w_countClamp = {1'b0, rx_data};
    if (rx_data == 8'h00) begin
      w_countClamp = BURST_MAX;
    end else if ({1'b0, rx_data} > BURST_MAX) begin
      w_countClamp = BURST_MAX;
    end
  end

  // State register.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Next-state decode and handshake outputs.
  always_comb begin
    w_stateNext = r_state;
    rx_ready    = 1'b0;
    tx_valid    = 1'b0;
    mem_valid   = 1'b0;
    mem_wstrb   = '0;
    case (r_state)
      S_IDLE: begin
        rx_ready = ~RESET;
        if (w_rxFire) begin
          case (rx_data)
            OP_SET_ADDR, OP_WRITE, OP_BURST_WR,
            OP_BURST_RD, OP_CPU_CLK: w_stateNext = S_ARGS;
            OP_READ:                 w_stateNext = S_MEM_RD;
            default:                 w_stateNext = FINISH_STATE;
          endcase
        end
      end
      S_ARGS: begin
        rx_ready = ~RESET;
        if (w_rxFire && w_lastArg) begin
          case (r_op)
            OP_SET_ADDR, OP_CPU_CLK: w_stateNext = FINISH_STATE;
            OP_WRITE:                w_stateNext = S_MEM_WR;
            OP_BURST_WR:             w_stateNext = r_cntPhase ? S_ARGS : S_MEM_WR;
            OP_BURST_RD:             w_stateNext = S_MEM_RD;
            default:                 w_stateNext = S_IDLE;
          endcase
        end
      end
      S_MEM_WR: begin
        mem_valid = 1'b1;
        mem_wstrb = '1;
        if (mem_ready) begin
          w_stateNext = w_moreWords ? S_ARGS : FINISH_STATE;
        end
      end
      S_MEM_RD: begin
        mem_valid = 1'b1;
        if (mem_ready) begin
          w_stateNext = S_TX;
        end
      end
      S_TX: begin
        tx_valid = 1'b1;
        if (tx_ready && w_lastTx) begin
          w_stateNext = w_moreWords ? S_MEM_RD : FINISH_STATE;
        end
      end
      S_ACK: begin
        tx_valid = 1'b1;
        if (tx_ready) begin
          w_stateNext = S_IDLE;
        end
      end
      default: w_stateNext = S_IDLE;
    endcase
  end

  // Command bookkeeping: opcode, argument counters, burst length, address
  // pointer and the CPU clock enable.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_op        <= 8'h00;
      r_argCnt    <= '0;
      r_argLen    <= '0;
      r_cntPhase  <= 1'b0;
      r_burstLeft <= 9'd0;
      r_addr      <= '0;
      r_txCnt     <= '0;
      r_cpuClkEn  <= 1'b1;
`ifdef DBGU_ACK_EN
      r_ackByte   <= 8'h00;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_rxFire) begin
            r_op        <= rx_data;
            r_argCnt    <= '0;
            r_cntPhase  <= 1'b0;
            r_burstLeft <= 9'd1;
            r_txCnt     <= '0;
`ifdef DBGU_ACK_EN
            r_ackByte   <= dbgu_known_op(rx_data) ? ACK_OK : ACK_BAD;
`endif
            case (rx_data)
              OP_SET_ADDR: r_argLen <= LEN_ADDR;
              OP_WRITE:    r_argLen <= LEN_DATA;
              OP_BURST_WR, OP_BURST_RD: begin
                r_argLen   <= LEN_ONE;
                r_cntPhase <= 1'b1;
              end
              OP_CPU_CLK:  r_argLen <= LEN_ONE;
              default:     r_argLen <= r_argLen;
            endcase
          end
        end
        S_ARGS: begin
          if (w_rxFire) begin
            if (w_lastArg) begin
              r_argCnt <= '0;
              case (r_op)
                OP_SET_ADDR: r_addr     <= w_argWord[ADDR_W-1:0];
                OP_CPU_CLK:  r_cpuClkEn <= rx_data[0];
                OP_BURST_WR, OP_BURST_RD: begin
                  if (r_cntPhase) begin
                    r_burstLeft <= w_countClamp;
                    r_cntPhase  <= 1'b0;
                    r_argLen    <= LEN_DATA;
                  end
                end
                default: r_argCnt <= '0;
              endcase
            end else begin
              r_argCnt <= r_argCnt + IW'(1);
            end
          end
        end
        S_MEM_WR: begin
          if (mem_ready) begin
            r_addr      <= r_addr + ADDR_STEP;
            r_burstLeft <= r_burstLeft - 9'd1;
          end
        end
        S_MEM_RD: begin
          if (mem_ready) begin
            r_addr  <= r_addr + ADDR_STEP;
            r_txCnt <= '0;
          end
        end
        S_TX: begin
          if (tx_ready) begin
            if (w_lastTx) begin
              r_txCnt     <= '0;
              r_burstLeft <= r_burstLeft - 9'd1;
            end else begin
              r_txCnt <= r_txCnt + TW'(1);
            end
          end
        end
        default: r_txCnt <= r_txCnt;
      endcase
    end
  end

`ifdef DBGU_ACK_EN
  assign tx_data = (r_state == S_ACK) ? r_ackByte : w_txQ[7:0];
`else
  assign tx_data = w_txQ[7:0];
`endif

  assign mem_addr     = r_addr & ~LOW_MASK;
  assign mem_wdata    = w_rxQ[DW-1:0];
  assign cpu_clk_en   = r_cpuClkEn;
  assign w_unusedBits = ^{w_txQ, w_argWord};

endmodule

// File: tb/tb_dbgu_burst.sv
// tb_dbgu_burst: directed bench for dbgu_burst (default build, no acks).
// A small bus responder with a memory model and a tx sink run alongside.
module tb_dbgu_burst;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic        mem_valid;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata = 32'h0;
  logic        cpu_clk_en;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] expAddr;
  } vec_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } bus_t;

  bus_t        busQ[$];
  logic [7:0]  txQ[$];
  logic [31:0] memModel [logic [31:0]];
  int          total = 0;
  int          bad = 0;
  int          rdyDelay = 0;
  int          waitCnt = 0;
  bit          txStall = 1'b0;

  always #5 CLK = ~CLK;

  dbgu_burst #(.ADDR_W(32), .DATA_BYTES(4), .MAX_BURST(4)) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .mem_valid  (mem_valid),
    .mem_ready  (mem_ready),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wstrb  (mem_wstrb),
    .mem_rdata  (mem_rdata),
    .cpu_clk_en (cpu_clk_en)
  );

  // Bus responder: waits rdyDelay cycles, then answers for one cycle and logs.
  always @(negedge CLK) begin
    if (RESET) begin
      mem_ready = 1'b0;
      waitCnt = 0;
    end else if (mem_ready) begin
      mem_ready = 1'b0;
      waitCnt = 0;
    end else if (mem_valid) begin
      if (waitCnt >= rdyDelay) begin
        busQ.push_back({mem_addr, mem_wdata, mem_wstrb});
        if (mem_wstrb != 4'h0) memModel[mem_addr] = mem_wdata;
        mem_rdata = memModel.exists(mem_addr) ? memModel[mem_addr] : 32'h0;
        mem_ready = 1'b1;
      end else begin
        waitCnt++;
      end
    end
  end

  // Response sink: optionally stalls tx_ready and records accepted bytes.
  always @(negedge CLK) begin
    tx_ready = txStall ? ($urandom_range(0, 2) != 0) : 1'b1;
    if (tx_ready && tx_valid && !RESET) txQ.push_back(tx_data);
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [63:0] act,
                             input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] b);
    int guard = 0;
    @(negedge CLK);
    rx_data = b;
    rx_valid = 1'b1;
    while (!rx_ready && guard < 2000) begin
      @(negedge CLK);
      guard++;
    end
    if (!rx_ready) begin
      checkOutput("rxAccept", {56'h0, b}, 64'h100);
      rx_valid = 1'b0;
    end else begin
      @(posedge CLK);
      #1;
      rx_valid = 1'b0;
    end
  endtask

  task automatic sendWord(input logic [31:0] w);
    for (int i = 0; i < 4; i++) applyStimulus(w[i*8 +: 8]);
  endtask

  task automatic waitBus(input int n, input string name);
    int guard = 0;
    while (busQ.size() < n && guard < 3000) begin
      @(negedge CLK);
      guard++;
    end
    repeat (8) @(negedge CLK);
    checkOutput({name, "Count"}, busQ.size(), n);
  endtask

  task automatic waitTx(input int n, input string name);
    int guard = 0;
    while (txQ.size() < n && guard < 3000) begin
      @(negedge CLK);
      guard++;
    end
    repeat (8) @(negedge CLK);
    checkOutput({name, "Count"}, txQ.size(), n);
  endtask

  function automatic logic [31:0] txWord(input int base);
    logic [31:0] w;
    w = 32'h0;
    for (int i = 0; i < 4; i++)
      if (base + i < txQ.size()) w[i*8 +: 8] = txQ[base + i];
    return w;
  endfunction

  task automatic checkReset(input string name);
    checkOutput({name, "MemValid"}, mem_valid, 1'b0);
    checkOutput({name, "Wstrb"}, mem_wstrb, 4'h0);
    checkOutput({name, "Addr"}, mem_addr, 32'h0);
    checkOutput({name, "Wdata"}, mem_wdata, 32'h0);
    checkOutput({name, "TxValid"}, tx_valid, 1'b0);
    checkOutput({name, "TxData"}, tx_data, 8'h00);
    checkOutput({name, "RxReady"}, rx_ready, 1'b0);
    checkOutput({name, "CpuEn"}, cpu_clk_en, 1'b1);
  endtask

  initial begin
    vec_t vecs[4];
    logic [31:0] rdExp[3];

    vecs[0] = '{addr: 32'h0000_1000, data: 32'hDEAD_BEEF, expAddr: 32'h0000_1000};
    vecs[1] = '{addr: 32'h0000_2003, data: 32'h0102_0304, expAddr: 32'h0000_2000};
    vecs[2] = '{addr: 32'h8000_0006, data: 32'hCAFE_F00D, expAddr: 32'h8000_0004};
    vecs[3] = '{addr: 32'hFFFF_FFFF, data: 32'h0F0F_0F0F, expAddr: 32'hFFFF_FFFC};

    $display("[TB] reset state");
    repeat (3) @(negedge CLK);
    checkReset("rst");
    RESET = 1'b0;
    repeat (2) @(negedge CLK);

    $display("[TB] cpu clock enable");
    applyStimulus(8'h22);
    checkOutput("cpuEnHeld", cpu_clk_en, 1'b1);
    applyStimulus(8'h00);
    checkOutput("cpuEnOff", cpu_clk_en, 1'b0);
    applyStimulus(8'h22);
    applyStimulus(8'h01);
    checkOutput("cpuEnOn", cpu_clk_en, 1'b1);

    $display("[TB] single write/read table");
    for (int i = 0; i < 4; i++) begin
      busQ.delete();
      txQ.delete();
      applyStimulus(8'h01);
      sendWord(vecs[i].addr);
      applyStimulus(8'h04);
      sendWord(vecs[i].data);
      waitBus(1, "tblWr");
      if (busQ.size() > 0) begin
        checkOutput("tblWrAddr", busQ[0].addr, vecs[i].expAddr);
        checkOutput("tblWrData", busQ[0].wdata, vecs[i].data);
        checkOutput("tblWrStrb", busQ[0].wstrb, 4'hF);
      end
      busQ.delete();
      applyStimulus(8'h01);
      sendWord(vecs[i].addr);
      applyStimulus(8'h05);
      waitBus(1, "tblRd");
      if (busQ.size() > 0) begin
        checkOutput("tblRdAddr", busQ[0].addr, vecs[i].expAddr);
        checkOutput("tblRdStrb", busQ[0].wstrb, 4'h0);
      end
      waitTx(4, "tblTx");
      checkOutput("tblTxWord", txWord(0), vecs[i].data);
    end

    $display("[TB] consecutive writes");
    busQ.delete();
    applyStimulus(8'h01);
    sendWord(32'h0002_0000);
    applyStimulus(8'h04);
    sendWord(32'hAABB_CCDD);
    applyStimulus(8'h04);
    sendWord(32'hAABB_CCDD);
    waitBus(2, "seqWr");
    if (busQ.size() > 1) begin
      checkOutput("seqWrAddr0", busQ[0].addr, 32'h0002_0000);
      checkOutput("seqWrAddr1", busQ[1].addr, 32'h0002_0004);
      checkOutput("seqWrData0", busQ[0].wdata, 32'hAABB_CCDD);
      checkOutput("seqWrData1", busQ[1].wdata, 32'hAABB_CCDD);
      checkOutput("seqWrStrb1", busQ[1].wstrb, 4'hF);
    end

    $display("[TB] burst write across address wrap");
    busQ.delete();
    applyStimulus(8'h01);
    sendWord(32'hFFFF_FFFC);
    applyStimulus(8'h06);
    applyStimulus(8'h02);
    sendWord(32'h4433_2211);
    sendWord(32'h8877_6655);
    waitBus(2, "wrapWr");
    if (busQ.size() > 1) begin
      checkOutput("wrapAddr0", busQ[0].addr, 32'hFFFF_FFFC);
      checkOutput("wrapAddr1", busQ[1].addr, 32'h0000_0000);
      checkOutput("wrapData0", busQ[0].wdata, 32'h4433_2211);
      checkOutput("wrapData1", busQ[1].wdata, 32'h8877_6655);
    end

    $display("[TB] unknown opcode");
    busQ.delete();
    txQ.delete();
    applyStimulus(8'h99);
    repeat (10) @(negedge CLK);
    checkOutput("unkBus", busQ.size(), 0);
    checkOutput("unkTx", txQ.size(), 0);
    checkOutput("unkIdle", rx_ready, 1'b1);

    $display("[TB] burst read with slow bus and tx stalls");
    memModel[32'h0000_0100] = 32'h1122_3344;
    memModel[32'h0000_0104] = 32'h5566_7788;
    memModel[32'h0000_0108] = 32'h99AA_BBCC;
    rdExp[0] = 32'h1122_3344;
    rdExp[1] = 32'h5566_7788;
    rdExp[2] = 32'h99AA_BBCC;
    busQ.delete();
    txQ.delete();
    rdyDelay = 5;
    txStall = 1'b1;
    applyStimulus(8'h01);
    sendWord(32'h0000_0100);
    applyStimulus(8'h07);
    applyStimulus(8'h03);
    waitBus(3, "brd");
    waitTx(12, "brdTx");
    for (int i = 0; i < 3; i++) begin
      if (busQ.size() > i) begin
        checkOutput("brdAddr", busQ[i].addr, 32'h0000_0100 + 32'(4 * i));
        checkOutput("brdStrb", busQ[i].wstrb, 4'h0);
      end
      checkOutput("brdWord", txWord(4 * i), rdExp[i]);
    end
    rdyDelay = 0;
    txStall = 1'b0;

    $display("[TB] burst count clamping");
    busQ.delete();
    txQ.delete();
    applyStimulus(8'h01);
    sendWord(32'h0000_0200);
    applyStimulus(8'h07);
    applyStimulus(8'h00);
    waitBus(4, "clampZero");
    waitTx(16, "clampZeroTx");
    if (busQ.size() > 3) checkOutput("clampZeroLast", busQ[3].addr, 32'h0000_020C);
    busQ.delete();
    txQ.delete();
    applyStimulus(8'h07);
    applyStimulus(8'h09);
    waitBus(4, "clampBig");
    waitTx(16, "clampBigTx");
    if (busQ.size() > 3) begin
      checkOutput("clampBigFirst", busQ[0].addr, 32'h0000_0210);
      checkOutput("clampBigLast", busQ[3].addr, 32'h0000_021C);
    end

    $display("[TB] reset in the middle of a write");
    applyStimulus(8'h22);
    applyStimulus(8'h00);
    busQ.delete();
    txQ.delete();
    applyStimulus(8'h04);
    applyStimulus(8'hDD);
    applyStimulus(8'hCC);
    @(negedge CLK);
    rx_data = 8'hBB;
    rx_valid = 1'b1;
    #2;
    RESET = 1'b1;
    #1;
    checkReset("midRst");
    rx_valid = 1'b0;
    repeat (2) @(negedge CLK);
    RESET = 1'b0;
    repeat (5) @(negedge CLK);
    checkOutput("midRstNoBus", busQ.size(), 0);
    applyStimulus(8'h05);
    waitBus(1, "postRst");
    if (busQ.size() > 0) begin
      checkOutput("postRstAddr", busQ[0].addr, 32'h0000_0000);
      checkOutput("postRstStrb", busQ[0].wstrb, 4'h0);
    end
    waitTx(4, "postRstTx");
    checkOutput("postRstWord", txWord(0), 32'h8877_6655);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
